// File: rtl/i2c_periph_pkg.sv
// Shared types and defaults for the I2C peripheral front end.
// Holds the arbiter state encoding and the default channel/tick sizing.
package i2c_periph_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

   localparam int DEFAULT_TICK_DIV = 250000;
   localparam int DEFAULT_NUM_CH   = 4;

endpackage

// File: rtl/debounce_event_arbiter_sample_tick_gen.sv
// Slow sample-tick generator: a free-running 0..TICK_DIV-1 counter whose
// terminal count yields a one-cycle tick enable in the system clock domain.
module sample_tick_gen
   import i2c_periph_pkg::*;
#(
   parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
   input  logic clk_in,
   input  logic rst_in,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_r;

   // Count up and wrap at the terminal count.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/debounce_event_arbiter.sv
// Tick-sampled debouncer with one pending event per channel and a round-robin
// valid/ready arbiter. DEBOUNCE_ARB_OVF_EN enables the sticky lost-event flag.
module debounce_event_arbiter
   import i2c_periph_pkg::*;
#(
   parameter int NUM_CH   = DEFAULT_NUM_CH,
   parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [NUM_CH-1:0]         signal_in,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [$clog2(NUM_CH)-1:0] evt_id,
   output logic [NUM_CH-1:0]         pending,
   output logic                      ovf_flag,
   input  logic                      ovf_clear
);

   localparam int ID_W = $clog2(NUM_CH);
   localparam logic [ID_W-1:0] LAST_CH = ID_W'(NUM_CH - 1);

   logic              tick_s;
   logic              tick_d_r;
   logic [NUM_CH-1:0] s1_r;
   logic [NUM_CH-1:0] s2_r;
   logic [NUM_CH-1:0] rise_s;
   logic [NUM_CH-1:0] pending_r;
   logic [NUM_CH-1:0] clr_s;
   logic [NUM_CH-1:0] pending_nxt_s;

   arb_state_t        state_r;
   arb_state_t        state_nxt_s;
   logic              evt_valid_r;
   logic              evt_valid_nxt_s;
   logic [ID_W-1:0]   evt_id_r;
   logic [ID_W-1:0]   evt_id_nxt_s;
   logic [ID_W-1:0]   last_grant_r;
   logic [ID_W-1:0]   last_grant_nxt_s;
   logic [ID_W-1:0]   idx_s;
   logic [ID_W-1:0]   gnt_s;
   logic              found_s;

   sample_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .tick   (tick_s)
   );

   // Rise is only evaluated in the cycle after a tick, once per sample period.
   assign rise_s        = {NUM_CH{tick_d_r}} & s1_r & ~s2_r;
   assign pending_nxt_s = (pending_r & ~clr_s) | rise_s;

   // Two-stage tick-enabled sampler and the pending-event vector.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_r      <= {NUM_CH{1'b0}};
         s2_r      <= {NUM_CH{1'b0}};
         tick_d_r  <= 1'b0;
         pending_r <= {NUM_CH{1'b0}};
      end else begin
         if (tick_s) begin
            s1_r <= signal_in;
            s2_r <= s1_r;
         end else begin
            s1_r <= s1_r;
            s2_r <= s2_r;
         end
         tick_d_r  <= tick_s;
         pending_r <= pending_nxt_s;
      end
   end

   // Round-robin search from last_grant+1, then the IDLE/OFFER handshake.
   always_comb begin
      found_s          = 1'b0;
      gnt_s            = {ID_W{1'b0}};
      idx_s            = {ID_W{1'b0}};
      clr_s            = {NUM_CH{1'b0}};
      state_nxt_s      = state_r;
      evt_valid_nxt_s  = evt_valid_r;
      evt_id_nxt_s     = evt_id_r;
      last_grant_nxt_s = last_grant_r;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx_s = ID_W'((int'(last_grant_r) + k) % NUM_CH);
         if (!found_s && pending_r[idx_s]) begin
            found_s = 1'b1;
            gnt_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
      case (state_r)
         IDLE: begin
            if (found_s) begin
               clr_s           = {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_s;
               evt_id_nxt_s    = gnt_s;
               evt_valid_nxt_s = 1'b1;
               state_nxt_s     = OFFER;
            end else begin
               evt_valid_nxt_s = 1'b0;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               last_grant_nxt_s = evt_id_r;
               evt_valid_nxt_s  = 1'b0;
               state_nxt_s      = IDLE;
            end else begin
               evt_valid_nxt_s  = 1'b1;
            end
         end
         default: begin
            evt_valid_nxt_s = 1'b0;
            state_nxt_s     = IDLE;
         end
      endcase
   end

   // Arbiter state and registered handshake outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r      <= IDLE;
         evt_valid_r  <= 1'b0;
         evt_id_r     <= {ID_W{1'b0}};
         last_grant_r <= LAST_CH;
      end else begin
         state_r      <= state_nxt_s;
         evt_valid_r  <= evt_valid_nxt_s;
         evt_id_r     <= evt_id_nxt_s;
         last_grant_r <= last_grant_nxt_s;
      end
   end

`ifdef DEBOUNCE_ARB_OVF_EN
   logic lost_s;
   logic ovf_r;

   assign lost_s = |(rise_s & pending_r & ~clr_s);

   // Sticky lost-event flag; a new loss beats a same-cycle clear.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ovf_r <= 1'b0;
      end else if (lost_s) begin
         ovf_r <= 1'b1;
      end else if (ovf_clear) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf_flag = ovf_r;
`else
   logic unused_ovf_clear_s;

   assign unused_ovf_clear_s = ovf_clear;
   assign ovf_flag           = 1'b0;
`endif

   assign evt_valid = evt_valid_r;
   assign evt_id    = evt_id_r;
   assign pending   = pending_r;

endmodule
